// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the register hazard scoreboard.
package hazard_scoreboard_pkg;
  localparam int NREGS         = 32;
  localparam int REG_IDX_W     = 5;
  localparam int STALL_MAX_DEF = 64;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } sb_state_e;
endpackage

// File: rtl/hazard_scoreboard_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module scoreboard_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 q <= '0;
    else if (clr)               q <= '0;
    else if (inc && (q != '1))  q <= q + W'(1);
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight write tracker: stalls decode on RAW/WAW hazards against pending
// writebacks, with same-cycle writeback bypass and a deadlock watchdog.
//
// state | meaning
// RUN   | decode advancing, no hazard last cycle
// STALL | decode held by a hazard last cycle
module hazard_scoreboard
  import hazard_scoreboard_pkg::sb_state_e;
  import hazard_scoreboard_pkg::RUN;
  import hazard_scoreboard_pkg::STALL;
  import hazard_scoreboard_pkg::REG_IDX_W;
  import hazard_scoreboard_pkg::STALL_MAX_DEF;
#(
  parameter int NREGS     = hazard_scoreboard_pkg::NREGS,
  parameter int STALL_MAX = STALL_MAX_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_dst,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_use_src1,
  input  logic                 id_use_src2,
  input  logic                 id_writes_dst,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_dst,
  input  logic                 flush,
  output logic                 id_stall,
  output logic [NREGS-1:0]     pending,
  output logic                 state,
  output logic [7:0]           stall_run,
  output logic [CNT_W-1:0]     stall_total,
  output logic                 err_deadlock
);
  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] pend_eff;
  logic             hazard;
  logic             issue;
  sb_state_e        state_q;
  sb_state_e        state_d;

  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_dst] = 1'b1;
  end

  assign pend_eff = pending & ~wb_mask;
  assign hazard   = (id_use_src1   & pend_eff[id_src1])
                  | (id_use_src2   & pend_eff[id_src2])
                  | (id_writes_dst & pend_eff[id_dst]);

  // Reset gates the stall so a held-in-reset pipeline never sees a hold.
  assign id_stall = rst_n & id_valid & hazard & ~flush;
  assign issue    = id_valid & ~id_stall & ~flush;

  always_comb begin
    set_mask = '0;
    if (issue && id_writes_dst) set_mask[id_dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pending <= '0;
    else if (flush) pending <= '0;
    else            pending <= pend_eff | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (!flush && id_stall) state_d = STALL;
  end

  assign state = state_q;

  scoreboard_sat_cnt #(.W(8)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (id_stall),
    .clr   (~id_stall),
    .q     (stall_run)
  );

  scoreboard_sat_cnt #(.W(CNT_W)) u_total_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (id_stall),
    .clr   (1'b0),
    .q     (stall_total)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_deadlock <= 1'b0;
    else if (flush)
      err_deadlock <= 1'b0;
    else if (id_stall && ((int'(stall_run) + 1) == STALL_MAX))
      err_deadlock <= 1'b1;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: driver pushes expected outputs from a reference model,
// a monitor on the falling edge pops and compares.
module tb_hazard_scoreboard;
  localparam int SMAX = 4;
  localparam int CW   = 4;

  logic        clk, rst_n;
  logic        id_valid, id_use_src1, id_use_src2, id_writes_dst, wb_valid, flush;
  logic [4:0]  id_dst, id_src1, id_src2, wb_dst;
  logic        id_stall, state, err_deadlock;
  logic [31:0] pending;
  logic [7:0]  stall_run;
  logic [CW-1:0] stall_total;

  hazard_scoreboard #(.NREGS(32), .STALL_MAX(SMAX), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_dst(id_dst),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
    .id_use_src2(id_use_src2), .id_writes_dst(id_writes_dst),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush), .id_stall(id_stall),
    .pending(pending), .state(state), .stall_run(stall_run),
    .stall_total(stall_total), .err_deadlock(err_deadlock));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          stall;
    logic [31:0] pend;
    bit          st;
    int          run;
    int          tot;
    bit          err;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_busy[32];
  int m_run, m_tot;
  bit m_err, m_st;

  task automatic chk(input string nm, input string tag, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, nm, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_stall",     e.tag, 32'(id_stall),     32'(e.stall));
        chk("pending",      e.tag, pending,           e.pend);
        chk("state",        e.tag, 32'(state),        32'(e.st));
        chk("stall_run",    e.tag, 32'(stall_run),    32'(e.run));
        chk("stall_total",  e.tag, 32'(stall_total),  32'(e.tot));
        chk("err_deadlock", e.tag, 32'(err_deadlock), 32'(e.err));
      end
    end
  end

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_run = 0; m_tot = 0; m_err = 1'b0; m_st = 1'b0;
  endtask

  // One cycle: drive at posedge+1, record expectations, advance model.
  task automatic cyc(input string tag, input bit r, input bit v, input int dst,
                     input int s1, input int s2, input bit u1, input bit u2,
                     input bit wd, input bit wbv, input int wbd, input bit fl);
    exp_t e;
    bit eff[32];
    bit haz, stl, iss;
    rst_n = r; id_valid = v; id_dst = 5'(dst); id_src1 = 5'(s1); id_src2 = 5'(s2);
    id_use_src1 = u1; id_use_src2 = u2; id_writes_dst = wd;
    wb_valid = wbv; wb_dst = 5'(wbd); flush = fl;
    if (!r) model_reset();
    foreach (eff[i]) eff[i] = m_busy[i] && !(wbv && wbd == i);
    haz = (u1 && eff[s1]) || (u2 && eff[s2]) || (wd && eff[dst]);
    stl = r && v && haz && !fl;
    iss = v && !stl && !fl;
    e.tag = tag; e.stall = stl; e.st = m_st; e.run = m_run; e.tot = m_tot; e.err = m_err;
    e.pend = '0;
    foreach (m_busy[i]) e.pend[i] = m_busy[i];
    q.push_back(e);
    if (r) begin
      if (fl) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_err = 1'b0;
      end else begin
        if (wbv) m_busy[wbd] = 1'b0;
        if (iss && wd) m_busy[dst] = 1'b1;
        if (stl && m_run + 1 == SMAX) m_err = 1'b1;
      end
      m_run = stl ? ((m_run < 255) ? m_run + 1 : 255) : 0;
      if (stl && m_tot < (1 << CW) - 1) m_tot++;
      m_st = stl;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : driver
    rst_n = 1'b0; id_valid = 0; id_dst = 0; id_src1 = 0; id_src2 = 0;
    id_use_src1 = 0; id_use_src2 = 0; id_writes_dst = 0;
    wb_valid = 0; wb_dst = 0; flush = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset("reset");
    // RAW with first issue right after reset release
    cyc("raw_issue", 1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("raw_stall", 1, 1, 9, 5, 0, 1, 0, 0, 0, 0, 0);
    cyc("raw_stall", 1, 1, 9, 5, 0, 1, 0, 0, 0, 0, 0);
    cyc("raw_wb",    1, 1, 9, 5, 0, 1, 0, 0, 1, 5, 0);
    idle("raw_after");
    // Bypass plus re-set of the same register
    cyc("byp_set", 1, 1, 7, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("byp_wb",  1, 1, 7, 0, 0, 0, 0, 1, 1, 7, 0);
    idle("byp_after");
    // WAW
    cyc("waw_set",   1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("waw_stall", 1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("waw_stall", 1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("waw_wb",    1, 1, 3, 0, 0, 0, 0, 1, 1, 3, 0);
    idle("waw_after");
    // Writeback to a non-pending register is ignored
    cyc("wb_stray", 1, 0, 0, 0, 0, 0, 0, 0, 1, 20, 0);
    idle("wb_stray_after");
    // Deadlock from a clean counter state
    do_reset("dl_reset");
    cyc("dl_set", 1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("dl_hold", 1, 1, 1, 9, 0, 1, 0, 0, 0, 0, 0);
    cyc("dl_flush", 1, 1, 1, 9, 0, 1, 0, 0, 0, 0, 1);
    idle("dl_after");
    idle("dl_after2");
    // Counter saturation
    do_reset("sat_reset");
    cyc("sat_set", 1, 1, 12, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("sat_hold", 1, 1, 2, 0, 12, 0, 1, 0, 0, 0, 0);
    cyc("sat_release", 1, 1, 2, 0, 12, 0, 1, 0, 1, 12, 0);
    idle("sat_after");
    idle("sat_after2");
    // Async reset between edges
    cyc("ar_set0", 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("ar_set5", 1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("ar_hold", 1, 1, 6, 5, 0, 1, 0, 0, 0, 0, 0);
    cyc("ar_rst",  0, 1, 6, 5, 0, 1, 0, 0, 0, 0, 0);
    cyc("ar_first", 1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    idle("ar_after");
    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
    end
    idle("drain");
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
